biriscv_regfile_wb_ctrl: RTL and testbench
==========================================

# biriscv_regfile_wb_ctrl

Write-port controller for the 2-read/1-write integer register file. It arbitrates several writeback sources (ALU, load unit, mul/div, …) onto the single write port using valid/ready handshakes and round-robin priority. After reset it also runs a clear sequence that writes zero to x1–x31, because the LUT-RAM storage has no reset. It sits between the execute/writeback stages and the register file's `rd0_i`/`rd0_value_i` inputs.

## Interface
Parameters:
- `NUM_REQ`, default 3, number of writeback requesters (2..8).

Ports:
- `clk_i`  in  1  core clock; the register file writes on the same edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  NUM_REQ  requester i holds a result.
- `req_rd_i`  in  NUM_REQ*5  destination register; slice i is `[5i+4:5i]`.
- `req_value_i`  in  NUM_REQ*32  result data; slice i is `[32i+31:32i]`.
- `req_ready_o`  out  NUM_REQ  one-hot grant; a transfer happens when valid && ready.
- `rd0_o`  out  5  drives the register file `rd0_i`; 0 means no write.
- `rd0_value_o`  out  32  drives the register file `rd0_value_i`.
- `init_busy_o`  out  1  clear sequence in progress; issue logic must stall.

## Operation
- States: INIT and RUN. Reset enters INIT (or RUN when the clear feature is compiled out; see Configuration).
- INIT:
  - `req_ready_o` is all zeros.
  - A 5-bit counter starts at 1. Each cycle, `rd0_o` is loaded with the counter and `rd0_value_o` with 0, then the counter increments.
  - After the edge that loads 31, the next edge moves to RUN.
- RUN arbitration, round-robin:
  - The search starts at index `(last_grant+1) mod NUM_REQ`.
  - The first requester with valid set gets ready (at most one bit).
  - `last_grant` resets to `NUM_REQ-1`, so requester 0 has first priority.
  - `last_grant` updates only on an accepted transfer.
- `req_ready_o` is combinational from `req_valid_i`, state and `last_grant`; it never depends on itself. A requester must hold valid, rd and value stable until accepted.
- On a transfer, `rd0_o`/`rd0_value_o` register the winner's rd/value. With no transfer, `rd0_o` registers 0 (`rd0_value_o` holds its last value).
- A request with rd=0 is accepted normally, consumes its round-robin turn, and produces `rd0_o`=0, i.e. no write.
- Reset values: `rd0_o`=0, `rd0_value_o`=0, `last_grant`=NUM_REQ-1, counter=1. `init_busy_o` is 1 in INIT and 0 in RUN.
- Reset asserted mid-sequence or mid-transfer: all state returns to reset values immediately (asynchronous). Any in-flight `rd0_o` is dropped and the clear sequence restarts from x1.

## Timing
- Handshake at edge E makes `rd0_o` valid after E; the register file write lands at edge E+1. Request-to-architectural-write latency is therefore 2 edges.
- Between E and E+1, `rd0_o` names the in-flight register. Issue/bypass logic must compare source indices against `rd0_o` and stall or forward `rd0_value_o`.
- Throughput is one write per cycle. With all NUM_REQ continuously valid, each requester is granted once every NUM_REQ cycles.
- Clear sequence: `rd0_o` = 1..31 on the 31 cycles after reset release. `init_busy_o` falls on the 32nd edge, and the first grant is possible in that same cycle.

## Configuration
- `BIRISCV_REGFILE_CLEAR_EN` defined: INIT state and counter are present, with behaviour as above.
- Not defined: no INIT state or counter; reset enters RUN directly, `init_busy_o` is tied 0, and register contents after reset are undefined.

## Structure
- Package `biriscv_wb_pkg` holds:
  - `REG_IDX_W`=5, `XLEN`=32, `NUM_ARCH_REGS`=32;
  - the state enum `{WB_INIT, WB_RUN}`.
- Sub-module `biriscv_rr_arbiter` (parameter N):
  - inputs: request vector, last-grant index;
  - outputs: one-hot grant and encoded index;
  - purely combinational.
- This module keeps the pointer, FSM and output registers.

## Test plan
- Clear sequence (macro on): release reset → `rd0_o` steps 1,2,…,31 with value 0 on consecutive cycles; `init_busy_o` is 1 for 31 cycles, then 0. A read of x17 afterwards returns 0.
- Single write: after clear, req0 valid rd=5 value=0xDEADBEEF → `req_ready_o`=3'b001 the same cycle; `rd0_o`=5 next cycle; a port-A read of x5 returns 0xDEADBEEF one cycle later.
- Fairness: all three requesters valid for 6 cycles → grants 0,1,2,0,1,2; each value lands in its own rd.
- rd=0: req1 valid rd=0 value=0x1234 → accepted; `rd0_o`=0; x0 still reads 0. The next grant goes to req2 if it is valid.
- Reset mid-clear: assert `rst_n` low when `rd0_o`=12, release → `rd0_o` returns to 0, then restarts at 1; `init_busy_o` stays high for a full 31 cycles.
- Macro off: release reset → `init_busy_o`=0 immediately, and req2 rd=31 value=0xA5A5A5A5 is accepted in the first cycle.

Source files
------------

// File: rtl/biriscv_regfile_wb_ctrl_pkg.sv
// Shared constants and state encoding for the register-file writeback controller.
package biriscv_wb_pkg;

    localparam int REG_IDX_W     = 5;
    localparam int XLEN          = 32;
    localparam int NUM_ARCH_REGS = 32;

    typedef enum logic {
        WB_INIT = 1'b0,
        WB_RUN  = 1'b1
    } wb_state_e;

endpackage

// File: rtl/biriscv_regfile_wb_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last grant.
module biriscv_rr_arbiter #(
    parameter int N = 3
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] last_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] gnt_idx_o
);

    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        cand      = '0;
        found     = 1'b0;
        for (int unsigned off = 1; off <= N; off++) begin
            cand = IDX_W'((32'(last_i) + off) % N);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/biriscv_regfile_wb_ctrl.sv
// Writeback port controller: round-robin arbitration onto rd0, plus an optional
// post-reset clear of x1..x31 enabled by BIRISCV_REGFILE_CLEAR_EN.
module biriscv_regfile_wb_ctrl
    import biriscv_wb_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic                           clk_i,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [NUM_REQ*REG_IDX_W-1:0]   req_rd_i,
    input  logic [NUM_REQ*XLEN-1:0]        req_value_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    output logic [REG_IDX_W-1:0]           rd0_o,
    output logic [XLEN-1:0]                rd0_value_o,
    output logic                           init_busy_o
);

    localparam int               IDX_W    = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    logic                 run;
    logic                 clearing;
    logic [REG_IDX_W-1:0] clr_idx;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic                 xfer;
    logic [REG_IDX_W-1:0] win_rd;
    logic [XLEN-1:0]      win_value;

    logic [IDX_W-1:0]     last_grant_q, last_grant_d;
    logic [REG_IDX_W-1:0] rd0_q, rd0_d;
    logic [XLEN-1:0]      rd0_value_q, rd0_value_d;

`ifdef BIRISCV_REGFILE_CLEAR_EN
    wb_state_e            state_q, state_d;
    logic [REG_IDX_W-1:0] clr_cnt_q, clr_cnt_d;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WB_INIT;
            clr_cnt_q <= REG_IDX_W'(1);
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Leave INIT on the edge after x31 was loaded; the counter has wrapped to 0,
    // so that same edge loads rd0 with 0 (no write).
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == WB_INIT) begin
            clr_cnt_d = clr_cnt_q + REG_IDX_W'(1);
            if (rd0_q == REG_IDX_W'(NUM_ARCH_REGS - 1)) begin
                state_d = WB_RUN;
            end
        end
    end

    always_comb begin
        clearing = (state_q == WB_INIT);
        run      = (state_q == WB_RUN);
        clr_idx  = clr_cnt_q;
    end
`else
    assign clearing = 1'b0;
    assign run      = 1'b1;
    assign clr_idx  = '0;
`endif

    biriscv_rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req_i     (req_valid_i),
        .last_i    (last_grant_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx)
    );

    assign req_ready_o = run ? arb_gnt : '0;
    assign xfer        = |(req_valid_i & req_ready_o);

    always_comb begin
        win_rd    = req_rd_i[int'(arb_idx)*REG_IDX_W +: REG_IDX_W];
        win_value = req_value_i[int'(arb_idx)*XLEN +: XLEN];
    end

    always_comb begin
        rd0_d        = '0;
        rd0_value_d  = rd0_value_q;
        last_grant_d = last_grant_q;
        if (clearing) begin
            rd0_d       = clr_idx;
            rd0_value_d = '0;
        end else if (xfer) begin
            rd0_d        = win_rd;
            rd0_value_d  = win_value;
            last_grant_d = arb_idx;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= LAST_RST;
            rd0_q        <= '0;
            rd0_value_q  <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rd0_q        <= rd0_d;
            rd0_value_q  <= rd0_value_d;
        end
    end

    assign rd0_o       = rd0_q;
    assign rd0_value_o = rd0_value_q;
    assign init_busy_o = clearing;

endmodule

// File: tb/tb_biriscv_regfile_wb_ctrl.sv
// Bench for biriscv_regfile_wb_ctrl with NUM_REQ=3; follows BIRISCV_REGFILE_CLEAR_EN.
module tb_biriscv_regfile_wb_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req_valid_i = '0;
    logic [14:0] req_rd_i    = '0;
    logic [95:0] req_value_i = '0;
    logic [2:0]  req_ready_o;
    logic [4:0]  rd0_o;
    logic [31:0] rd0_value_o;
    logic        init_busy_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [32];

    typedef struct packed {
        logic [2:0]  valid;
        logic [14:0] rd;
        logic [95:0] value;
        logic [2:0]  exp_ready;
        logic [4:0]  exp_rd;
        logic [31:0] exp_val;
    } vec_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] val;
    } sb_t;

    vec_t vecs [12];
    sb_t  sbq [$];

    always #5 clk_i = ~clk_i;

    biriscv_regfile_wb_ctrl #(
        .NUM_REQ (3)
    ) dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_rd_i    (req_rd_i),
        .req_value_i (req_value_i),
        .req_ready_o (req_ready_o),
        .rd0_o       (rd0_o),
        .rd0_value_o (rd0_value_o),
        .init_busy_o (init_busy_o)
    );

    // Register file model fed by the controller's write port.
    initial for (int i = 0; i < 32; i++) mem[i] = 32'hFFFF_FFFF;
    always @(posedge clk_i) if (rd0_o != 5'd0) mem[rd0_o] <= rd0_value_o;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [95:0] vals(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return {c, b, a};
    endfunction

    function automatic logic [14:0] rds(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        return {c, b, a};
    endfunction

    task automatic release_reset();
        @(posedge clk_i);
        #3;
        rst_n = 1'b1;
    endtask

`ifdef BIRISCV_REGFILE_CLEAR_EN
    task automatic check_clear();
        req_valid_i = 3'b111;
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk_i);
            #1;
            check("clr_rd", 64'(rd0_o), 64'(k));
            check("clr_val", 64'(rd0_value_o), 64'd0);
            check("clr_busy", 64'(init_busy_o), 64'd1);
            check("clr_ready", 64'(req_ready_o), 64'd0);
        end
        req_valid_i = '0;
        @(posedge clk_i);
        #1;
        check("clr_done_busy", 64'(init_busy_o), 64'd0);
        check("clr_done_rd", 64'(rd0_o), 64'd0);
    endtask
`endif

    task automatic run_vec(input vec_t v, input int idx);
        sb_t s;
        req_valid_i = v.valid;
        req_rd_i    = v.rd;
        req_value_i = v.value;
        #1;
        check($sformatf("ready[%0d]", idx), 64'(req_ready_o), 64'(v.exp_ready));
        sbq.push_back({v.exp_rd, v.exp_val});
        @(posedge clk_i);
        #1;
        if (sbq.size() == 0) begin
            check("sb_underflow", 64'd1, 64'd0);
        end else begin
            s = sbq.pop_front();
            check($sformatf("rd0[%0d]", idx), 64'(rd0_o), 64'(s.rd));
            check($sformatf("val[%0d]", idx), 64'(rd0_value_o), 64'(s.val));
        end
    endtask

    initial begin
        // Round-robin sequence starting from last_grant=2 after reset.
        vecs[0]  = '{3'b001, rds(5, 0, 0),   vals(32'hDEADBEEF, 0, 0),              3'b001, 5'd5,  32'hDEADBEEF};
        vecs[1]  = '{3'b111, rds(10, 11, 12), vals(32'hA, 32'hB, 32'hC),             3'b010, 5'd11, 32'hB};
        vecs[2]  = '{3'b111, rds(10, 11, 12), vals(32'hA, 32'hB, 32'hC),             3'b100, 5'd12, 32'hC};
        vecs[3]  = '{3'b111, rds(10, 11, 12), vals(32'hA, 32'hB, 32'hC),             3'b001, 5'd10, 32'hA};
        vecs[4]  = '{3'b111, rds(10, 11, 12), vals(32'hA, 32'hB, 32'hC),             3'b010, 5'd11, 32'hB};
        vecs[5]  = '{3'b111, rds(10, 11, 12), vals(32'hA, 32'hB, 32'hC),             3'b100, 5'd12, 32'hC};
        vecs[6]  = '{3'b111, rds(10, 11, 12), vals(32'hA, 32'hB, 32'hC),             3'b001, 5'd10, 32'hA};
        vecs[7]  = '{3'b010, rds(10, 0, 12),  vals(32'hA, 32'h1234, 32'hC),          3'b010, 5'd0,  32'h1234};
        vecs[8]  = '{3'b110, rds(10, 11, 13), vals(32'hA, 32'hB, 32'h5555),          3'b100, 5'd13, 32'h5555};
        vecs[9]  = '{3'b000, rds(10, 11, 13), vals(32'hA, 32'hB, 32'h5555),          3'b000, 5'd0,  32'h5555};
        vecs[10] = '{3'b011, rds(20, 21, 22), vals(32'h20, 32'h21, 32'h22),          3'b001, 5'd20, 32'h20};
        vecs[11] = '{3'b110, rds(20, 21, 22), vals(32'h20, 32'h21, 32'h22),          3'b010, 5'd21, 32'h21};

        #20;
        check("rst_rd0", 64'(rd0_o), 64'd0);
        check("rst_val", 64'(rd0_value_o), 64'd0);
        check("rst_ready", 64'(req_ready_o), 64'd0);
`ifdef BIRISCV_REGFILE_CLEAR_EN
        check("rst_busy", 64'(init_busy_o), 64'd1);
        release_reset();
        check_clear();
        check("x17_cleared", 64'(mem[17]), 64'd0);
`else
        check("rst_busy", 64'(init_busy_o), 64'd0);
        release_reset();
        req_valid_i = 3'b100;
        req_rd_i    = rds(0, 0, 31);
        req_value_i = vals(0, 0, 32'hA5A5A5A5);
        #1;
        check("off_busy", 64'(init_busy_o), 64'd0);
        check("off_ready", 64'(req_ready_o), 64'b100);
        @(posedge clk_i);
        #1;
        check("off_rd0", 64'(rd0_o), 64'd31);
        check("off_val", 64'(rd0_value_o), 64'hA5A5A5A5);
`endif

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);
        req_valid_i = '0;
        #1;
        check("sb_empty", 64'(sbq.size()), 64'd0);
        check("x5_write", 64'(mem[5]), 64'hDEADBEEF);
        check("x10_write", 64'(mem[10]), 64'hA);
        check("x11_write", 64'(mem[11]), 64'hB);
        check("x12_write", 64'(mem[12]), 64'hC);
        check("x13_write", 64'(mem[13]), 64'h5555);

        // Reset during an in-flight write drops rd0 immediately.
        req_valid_i = 3'b001;
        req_rd_i    = rds(7, 0, 0);
        req_value_i = vals(32'h77, 0, 0);
        @(posedge clk_i);
        #1;
        check("inflight_rd0", 64'(rd0_o), 64'd7);
        req_valid_i = '0;
        rst_n = 1'b0;
        #1;
        check("async_rst_rd0", 64'(rd0_o), 64'd0);
        check("async_rst_val", 64'(rd0_value_o), 64'd0);
        release_reset();

`ifdef BIRISCV_REGFILE_CLEAR_EN
        check_clear();
        // Reset when rd0 reaches 12; the sequence must restart from x1.
        rst_n = 1'b0;
        #1;
        release_reset();
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk_i);
            #1;
        end
        check("midclr_rd12", 64'(rd0_o), 64'd12);
        rst_n = 1'b0;
        #1;
        check("midclr_rd0", 64'(rd0_o), 64'd0);
        check("midclr_busy", 64'(init_busy_o), 64'd1);
        #1;
        rst_n = 1'b1;
        check_clear();
`else
        // Pointer was reset: requester 0 wins first again.
        req_valid_i = 3'b011;
        #1;
        check("post_rst_ready", 64'(req_ready_o), 64'b001);
        req_valid_i = '0;
        @(posedge clk_i);
        #1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
